// File: rtl/decoder_rr_arbiter_pkg.sv
// Shared types and constants for the round-robin decoder-select arbiter.
package decoder_arb_pkg;

  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;
  localparam int HOLD_W  = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  // Expand an encoded select index into a one-hot grant vector.
  function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] s);
    logic [NUM_REQ-1:0] v;
    v    = '0;
    v[s] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/decoder_rr_arbiter_if.sv
// Request/grant bundle between requesters and the arbiter.
// Handshake: req[i] is a level request; the resource belongs to requester i
// exactly while gnt[i] is high, and the requester releases it by dropping req[i].
// state is a read-only view of the arbiter FSM for observation.
interface decoder_rr_arbiter_if;
  import decoder_arb_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [SEL_W-1:0]   sel;
  logic               busy;
  logic               timeout;
  state_t             state;

  modport master (output req, input gnt, input sel, input busy, input timeout, input state);
  modport slave  (input req, output gnt, output sel, output busy, output timeout, output state);
endinterface

// File: rtl/decoder_rr_arbiter_rr_pick4.sv
// Rotating priority encoder: first set request after ptr, wrapping around.
module rr_pick4
  import decoder_arb_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [SEL_W-1:0]   ptr,
  output logic               any,
  output logic [SEL_W-1:0]   idx
);

  // Scan from lowest to highest priority so the highest-priority hit wins last.
  always_comb begin
    logic [SEL_W-1:0] cand;
    any  = 1'b0;
    idx  = '0;
    cand = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand = ptr + SEL_W'(k);
      if (req[cand]) begin
        any = 1'b1;
        idx = cand;
      end
    end
  end

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter driving a 2-to-4 decoder select with a break-before-make
// idle cycle between grants and an optional cap on grant tenure.
module decoder_rr_arbiter
  import decoder_arb_pkg::*;
#(
  parameter int MAX_HOLD = 8
)(
  input logic                 clk,
  input logic                 rst,
  decoder_rr_arbiter_if.slave bus
);

  localparam logic [HOLD_W-1:0] HOLD_LIMIT = HOLD_W'(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_SAT   = '1;

  state_t             state_q, state_n;
  logic [SEL_W-1:0]   ptr_q, ptr_n;
  logic [HOLD_W-1:0]  cnt_q, cnt_n;
  logic [SEL_W-1:0]   sel_q, sel_n;
  logic [NUM_REQ-1:0] gnt_q, gnt_n;
  logic               busy_q, busy_n;
  logic               timeout_q, timeout_n;

  logic               pick_any;
  logic [SEL_W-1:0]   pick_idx;

  rr_pick4 u_pick (
    .req (bus.req),
    .ptr (ptr_q),
    .any (pick_any),
    .idx (pick_idx)
  );

  // Next-state and next-output logic; arbitration only happens in IDLE.
  always_comb begin
    state_n   = state_q;
    ptr_n     = ptr_q;
    cnt_n     = cnt_q;
    sel_n     = sel_q;
    gnt_n     = gnt_q;
    busy_n    = busy_q;
    timeout_n = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt_n  = '0;
        busy_n = 1'b0;
        if (pick_any) begin
          sel_n   = pick_idx;
          gnt_n   = onehot4(pick_idx);
          busy_n  = 1'b1;
          cnt_n   = HOLD_W'(1);
          state_n = GRANT;
        end
      end
      GRANT: begin
        if (!bus.req[sel_q] || (MAX_HOLD != 0 && cnt_q == HOLD_LIMIT)) begin
          // Releasing holder goes to the back of the rotation; sel keeps its value.
          ptr_n     = sel_q;
          state_n   = IDLE;
          gnt_n     = '0;
          busy_n    = 1'b0;
          cnt_n     = '0;
          timeout_n = bus.req[sel_q];
        end else if (cnt_q != HOLD_SAT) begin
          cnt_n = cnt_q + HOLD_W'(1);
        end
      end
      default: begin
        state_n = IDLE;
        gnt_n   = '0;
        busy_n  = 1'b0;
      end
    endcase
  end

  // State, pointer, counter and registered outputs; reset puts requester 0 first.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      ptr_q     <= 2'd3;
      cnt_q     <= '0;
      sel_q     <= '0;
      gnt_q     <= '0;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_n;
      ptr_q     <= ptr_n;
      cnt_q     <= cnt_n;
      sel_q     <= sel_n;
      gnt_q     <= gnt_n;
      busy_q    <= busy_n;
      timeout_q <= timeout_n;
    end
  end

  assign bus.gnt     = gnt_q;
  assign bus.sel     = sel_q;
  assign bus.busy    = busy_q;
  assign bus.timeout = timeout_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Directed bench for decoder_rr_arbiter: two instances (MAX_HOLD=2 and 8).
module tb_decoder_rr_arbiter;
  import decoder_arb_pkg::*;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  decoder_rr_arbiter_if bus2 ();
  decoder_rr_arbiter_if bus8 ();

  decoder_rr_arbiter #(.MAX_HOLD(2)) dut2 (.clk(clk), .rst(rst), .bus(bus2));
  decoder_rr_arbiter #(.MAX_HOLD(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  // Clock: 10 ns period.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect2(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({tag, ".gnt"}, 32'(bus2.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus2.sel), 32'(s));
    chk({tag, ".busy"}, 32'(bus2.busy), 32'(b));
    chk({tag, ".timeout"}, 32'(bus2.timeout), 32'(t));
  endtask

  task automatic expect8(input string tag, input logic [3:0] g, input logic [1:0] s,
                         input logic b, input logic t);
    chk({tag, ".gnt"}, 32'(bus8.gnt), 32'(g));
    chk({tag, ".sel"}, 32'(bus8.sel), 32'(s));
    chk({tag, ".busy"}, 32'(bus8.busy), 32'(b));
    chk({tag, ".timeout"}, 32'(bus8.timeout), 32'(t));
  endtask

  initial begin
    logic [3:0] exp_g;
    logic [1:0] w;
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    bus2.req = 4'b0000;
    bus8.req = 4'b0000;
    #1;
    expect2("rst_async2", 4'b0000, 2'b00, 1'b0, 1'b0);
    expect8("rst_async8", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;

    // Idle with no requests for 5 cycles.
    for (int i = 0; i < 5; i++) begin
      tick();
      expect2("idle2", 4'b0000, 2'b00, 1'b0, 1'b0);
      expect8("idle8", 4'b0000, 2'b00, 1'b0, 1'b0);
      chk("idle8.state", 32'(bus8.state), 32'(IDLE));
    end

    // All four requesting, MAX_HOLD=2: tenures 0,1,2,3,0 of 2 cycles + timeout gap.
    bus2.req = 4'b1111;
    for (int t = 0; t < 5; t++) begin
      w = 2'(t % 4);
      exp_g = 4'b0001 << w;
      tick();
      expect2("rr_full_c1", exp_g, w, 1'b1, 1'b0);
      tick();
      expect2("rr_full_c2", exp_g, w, 1'b1, 1'b0);
      tick();
      expect2("rr_full_gap", 4'b0000, w, 1'b0, 1'b1);
    end
    bus2.req = 4'b0000;
    tick();
    expect2("rr_full_off", 4'b0000, 2'b00, 1'b0, 1'b0);

    // Requester 2 alone for 3 cycles, then drops.
    bus8.req = 4'b0100;
    tick(); expect8("r2_c1", 4'b0100, 2'b10, 1'b1, 1'b0);
    tick(); expect8("r2_c2", 4'b0100, 2'b10, 1'b1, 1'b0);
    tick(); expect8("r2_c3", 4'b0100, 2'b10, 1'b1, 1'b0);
    bus8.req = 4'b0000;
    tick(); expect8("r2_rel", 4'b0000, 2'b10, 1'b0, 1'b0);
    chk("r2_rel.state", 32'(bus8.state), 32'(IDLE));
    tick(); expect8("r2_idle", 4'b0000, 2'b10, 1'b0, 1'b0);

    // ptr is now 2: 1101 picks requester 3 first.
    bus8.req = 4'b1101;
    tick(); expect8("after2", 4'b1000, 2'b11, 1'b1, 1'b0);
    bus8.req = 4'b1000;
    tick(); expect8("hold3", 4'b1000, 2'b11, 1'b1, 1'b0);

    // Asynchronous reset mid-grant: outputs clear before the next clock edge.
    #2;
    rst = 1'b1;
    #1;
    expect8("async_rst", 4'b0000, 2'b00, 1'b0, 1'b0);
    chk("async_rst.state", 32'(bus8.state), 32'(IDLE));
    #2;
    rst = 1'b0;
    bus8.req = 4'b1111;
    tick(); expect8("post_rst", 4'b0001, 2'b00, 1'b1, 1'b0);

    // Requester 0 holds, requester 1 joins, requester 0 drops.
    bus8.req = 4'b0001;
    tick(); expect8("r0_hold", 4'b0001, 2'b00, 1'b1, 1'b0);
    bus8.req = 4'b0011;
    tick(); expect8("r1_ignored", 4'b0001, 2'b00, 1'b1, 1'b0);
    bus8.req = 4'b0010;
    tick(); expect8("r0_drop", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick(); expect8("r1_grant", 4'b0010, 2'b01, 1'b1, 1'b0);

    // Sole requester 0 with MAX_HOLD=8: 8 granted cycles then a timeout gap.
    bus8.req = 4'b0001;
    tick(); expect8("sole_rel1", 4'b0000, 2'b01, 1'b0, 1'b0);
    for (int i = 0; i < 18; i++) begin
      tick();
      if ((i % 9) < 8) expect8("sole_grant", 4'b0001, 2'b00, 1'b1, 1'b0);
      else             expect8("sole_gap", 4'b0000, 2'b00, 1'b0, 1'b1);
    end
    bus8.req = 4'b0000;
    tick(); expect8("sole_rel2", 4'b0000, 2'b00, 1'b0, 1'b0);
    tick(); expect8("final_idle", 4'b0000, 2'b00, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
